// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: fetch/decode/exec/mem/writeback sequencing with memory wait timeout.
// Optional CTRL_ILLEGAL_TRAP_EN: illegal opcodes enter a sticky TRAP state instead of acting as a NOP.
module multicycle_controller #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        pc_we,
  output logic        pc_src,
  output logic        ir_we,
  output logic        alu_src,
  output logic        mem_req,
  output logic        mem_we,
  output logic        reg_we,
  output logic        wb_sel,
  output logic        mem_err,
  output logic        trap,
  output logic [1:0]  imm_sel,
  output logic [2:0]  state
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned OP_W  = 7;

  localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
  localparam logic [OP_W-1:0] OP_IALU   = 7'b0010011;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;

  logic [OP_W-1:0] opcode;
  logic is_load, is_store, is_branch, is_rtype, is_ialu, is_legal;
  logic mem_phase, timeout;
  logic unused_instr;

  logic pc_we_c, pc_src_c, ir_we_c, alu_src_c, mem_req_c, mem_we_c;
  logic reg_we_c, wb_sel_c, mem_err_c;
  logic [1:0] imm_sel_c;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic trap_c;
`endif

  assign opcode       = instr[OP_W-1:0];
  assign unused_instr = ^instr[31:OP_W];

  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_rtype  = (opcode == OP_RTYPE);
  assign is_ialu   = (opcode == OP_IALU);
  assign is_legal  = is_load | is_store | is_branch | is_rtype | is_ialu;

  // Timeout fires only while a request is outstanding and memory has not answered
  assign mem_phase = (state_q == S_FETCH) || (state_q == S_MEM);
  assign timeout   = mem_phase && !mem_ready && (wait_q == CNT_W'(WAIT_MAX));

  always_comb begin
    imm_sel_c = 2'b11;
    if (is_load || is_ialu) imm_sel_c = 2'b00;
    else if (is_store)      imm_sel_c = 2'b01;
    else if (is_branch)     imm_sel_c = 2'b10;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    pc_we_c   = 1'b0;
    pc_src_c  = 1'b0;
    ir_we_c   = 1'b0;
    alu_src_c = 1'b0;
    mem_req_c = 1'b0;
    mem_we_c  = 1'b0;
    reg_we_c  = 1'b0;
    wb_sel_c  = 1'b0;
    mem_err_c = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
    trap_c    = 1'b0;
`endif

    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (mem_ready) begin
          ir_we_c = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          mem_err_c = 1'b1;
        end
      end
      S_DECODE: begin
        if (is_legal) begin
          state_d = S_EXEC;
        end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          pc_we_c = 1'b1;
          state_d = S_FETCH;
`endif
        end
      end
      S_EXEC: begin
        alu_src_c = is_load | is_store | is_ialu;
        if (is_branch) begin
          pc_we_c  = 1'b1;
          pc_src_c = branch_taken;
          state_d  = S_FETCH;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else if (is_rtype || is_ialu) begin
          state_d = S_WB;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        mem_req_c = 1'b1;
        mem_we_c  = is_store;
        if (mem_ready) begin
          if (is_load) begin
            state_d = S_WB;
          end else begin
            pc_we_c = 1'b1;
            state_d = S_FETCH;
          end
        end else if (timeout) begin
          // Abort: skip writeback, advance past the faulting instruction
          mem_err_c = 1'b1;
          pc_we_c   = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_WB: begin
        reg_we_c = 1'b1;
        pc_we_c  = 1'b1;
        wb_sel_c = is_load;
        state_d  = S_FETCH;
      end
      S_TRAP: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        trap_c = 1'b1;
`else
        state_d = S_FETCH;
`endif
      end
      default: state_d = S_FETCH;
    endcase

    // Count stalled request cycles; any state change or timeout restarts the count
    if ((state_d == state_q) && mem_phase && !mem_ready && !timeout) begin
      wait_d = wait_q + CNT_W'(1);
    end
  end

  // Outputs forced low while reset is asserted, independent of the clock
  assign pc_we   = pc_we_c   & rst_n;
  assign pc_src  = pc_src_c  & rst_n;
  assign ir_we   = ir_we_c   & rst_n;
  assign alu_src = alu_src_c & rst_n;
  assign mem_req = mem_req_c & rst_n;
  assign mem_we  = mem_we_c  & rst_n;
  assign reg_we  = reg_we_c  & rst_n;
  assign wb_sel  = wb_sel_c  & rst_n;
  assign mem_err = mem_err_c & rst_n;
  assign imm_sel = imm_sel_c & {2{rst_n}};
  assign state   = 3'(state_q) & {3{rst_n}};
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign trap    = trap_c & rst_n;
`else
  assign trap    = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: zero-wait sequences, memory timeouts, illegal opcode, async reset.
module tb_multicycle_controller;

  localparam logic [9:0] PCW = 10'h200;
  localparam logic [9:0] PCS = 10'h100;
  localparam logic [9:0] IRW = 10'h080;
  localparam logic [9:0] ALU = 10'h040;
  localparam logic [9:0] MRQ = 10'h020;
  localparam logic [9:0] MWE = 10'h010;
  localparam logic [9:0] RWE = 10'h008;
  localparam logic [9:0] WBS = 10'h004;
  localparam logic [9:0] MER = 10'h002;
  localparam logic [9:0] TRP = 10'h001;

  localparam logic [31:0] I_RTYPE  = 32'h0020_81B3;
  localparam logic [31:0] I_LOAD   = 32'h0040_A103;
  localparam logic [31:0] I_STORE  = 32'h0020_A223;
  localparam logic [31:0] I_BRANCH = 32'h0020_8463;
  localparam logic [31:0] I_IALU   = 32'h0050_8093;
  localparam logic [31:0] I_ILLEG  = 32'h0000_007F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] instr = I_RTYPE;
  logic        mem_ready = 1'b1;
  logic        branch_taken = 1'b0;
  logic pc_we, pc_src, ir_we, alu_src, mem_req, mem_we, reg_we, wb_sel, mem_err, trap;
  logic [1:0] imm_sel;
  logic [2:0] state;
  logic [9:0] outs;

  int checks = 0;
  int passes = 0;

  multicycle_controller #(.WAIT_MAX(15)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we),
    .alu_src(alu_src), .mem_req(mem_req), .mem_we(mem_we), .reg_we(reg_we),
    .wb_sel(wb_sel), .mem_err(mem_err), .trap(trap), .imm_sel(imm_sel), .state(state)
  );

  assign outs = {pc_we, pc_src, ir_we, alu_src, mem_req, mem_we, reg_we, wb_sel, mem_err, trap};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Check state and output strobes for the current cycle, then advance one clock
  task automatic cyc(input string tag, input logic [2:0] st, input logic [9:0] o);
    #1;
    chk({tag, "_state"}, 32'(state), 32'(st));
    chk({tag, "_outs"}, 32'(outs), 32'(o));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_outs", 32'(outs), 32'd0);
    chk("rst_imm", 32'(imm_sel), 32'd0);
    @(posedge clk); #1;
    chk("rst_hold_outs", 32'(outs), 32'd0);
    rst_n = 1'b1;

    // R-type, zero wait
    instr = I_RTYPE;
    #1 chk("rtype_imm", 32'(imm_sel), 32'd3);
    cyc("rt_f", 3'd0, MRQ | IRW);
    cyc("rt_d", 3'd1, 10'h0);
    cyc("rt_e", 3'd2, 10'h0);
    cyc("rt_w", 3'd4, RWE | PCW);

    // Load, zero wait
    instr = I_LOAD;
    #1 chk("load_imm", 32'(imm_sel), 32'd0);
    cyc("ld_f", 3'd0, MRQ | IRW);
    cyc("ld_d", 3'd1, 10'h0);
    cyc("ld_e", 3'd2, ALU);
    cyc("ld_m", 3'd3, MRQ);
    cyc("ld_w", 3'd4, RWE | PCW | WBS);

    // Branch taken then not taken
    instr = I_BRANCH;
    branch_taken = 1'b1;
    #1 chk("br_imm", 32'(imm_sel), 32'd2);
    cyc("bt_f", 3'd0, MRQ | IRW);
    cyc("bt_d", 3'd1, 10'h0);
    cyc("bt_e", 3'd2, PCW | PCS);
    branch_taken = 1'b0;
    cyc("bn_f", 3'd0, MRQ | IRW);
    cyc("bn_d", 3'd1, 10'h0);
    cyc("bn_e", 3'd2, PCW);

    // I-ALU
    instr = I_IALU;
    cyc("ia_f", 3'd0, MRQ | IRW);
    cyc("ia_d", 3'd1, 10'h0);
    cyc("ia_e", 3'd2, ALU);
    cyc("ia_w", 3'd4, RWE | PCW);

    // Store with memory never ready: timeout on the 16th MEM cycle
    instr = I_STORE;
    #1 chk("st_imm", 32'(imm_sel), 32'd1);
    cyc("st_f", 3'd0, MRQ | IRW);
    cyc("st_d", 3'd1, 10'h0);
    cyc("st_e", 3'd2, ALU);
    mem_ready = 1'b0;
    for (int i = 1; i <= 15; i++) cyc("st_mwait", 3'd3, MRQ | MWE);
    cyc("st_mto", 3'd3, MRQ | MWE | MER | PCW);

    // Fetch timeout: stays in FETCH and restarts the count
    instr = I_ILLEG;
    for (int i = 1; i <= 15; i++) cyc("f_wait", 3'd0, MRQ);
    cyc("f_to", 3'd0, MRQ | MER);
    // Ready arriving on the count-limit cycle wins over the timeout
    for (int i = 1; i <= 15; i++) cyc("f_wait2", 3'd0, MRQ);
    mem_ready = 1'b1;
    cyc("f_race", 3'd0, MRQ | IRW);

    // Illegal opcode
`ifdef CTRL_ILLEGAL_TRAP_EN
    cyc("il_d", 3'd1, 10'h0);
    cyc("il_trap0", 3'd5, TRP);
    cyc("il_trap1", 3'd5, TRP);
    cyc("il_trap2", 3'd5, TRP);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    #1 chk("il_exit_state", 32'(state), 32'd0);
    @(posedge clk); #1;
`else
    cyc("il_d", 3'd1, PCW);
`endif

    // Reset dropped in MEM during a load
    instr = I_LOAD;
    cyc("rl_f", 3'd0, MRQ | IRW);
    cyc("rl_d", 3'd1, 10'h0);
    cyc("rl_e", 3'd2, ALU);
    mem_ready = 1'b0;
    #1 chk("rl_m_state", 32'(state), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("rl_async_outs", 32'(outs), 32'd0);
    chk("rl_async_state", 32'(state), 32'd0);
    @(posedge clk); #1;
    chk("rl_edge_outs", 32'(outs), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rl_rel_state", 32'(state), 32'd0);
    chk("rl_rel_outs", 32'(outs), 32'(MRQ));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench did not complete");
  end

endmodule
